// File: rtl/load_align_unit_if.sv
// Load request, data-memory read port and load response bundle.
// master drives requests/memory returns; slave is the load unit.
interface load_align_unit_if #(
   parameter int XLEN   = 32,
   parameter int ADDR_W = 32
);
   logic              reqValid;
   logic              reqReady;
   logic [2:0]        funct3;
   logic [ADDR_W-1:0] addr;
   logic              memReq;
   logic [ADDR_W-1:0] memAddr;
   logic              memAck;
   logic [XLEN-1:0]   memRdata;
   logic              rspValid;
   logic [XLEN-1:0]   rspData;
   logic              rspMisalign;
   logic              rspIllegal;

   modport master (
      output reqValid, funct3, addr, memAck, memRdata,
      input  reqReady, memReq, memAddr,
      input  rspValid, rspData, rspMisalign, rspIllegal
   );

   modport slave (
      input  reqValid, funct3, addr, memAck, memRdata,
      output reqReady, memReq, memAddr,
      output rspValid, rspData, rspMisalign, rspIllegal
   );
endinterface

// File: rtl/load_align_unit.sv
// Multi-cycle load formatter: aligned beat read(s), merge, extend.
// Optional MISALIGN_SPLIT_EN: split misaligned loads into two beats.
module load_align_unit #(
   parameter int XLEN   = 32,
   parameter int ADDR_W = 32
) (
   input logic             clk,
   input logic             reset,
   load_align_unit_if.slave bus
);
   localparam int NB = XLEN / 8;
   localparam int OW = $clog2(NB);
   localparam int SW = $clog2(XLEN) + 1;

   typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, RESP} state_t;

   state_t            r_state;
   state_t            w_next;
   logic [2:0]        r_f3;
   logic [OW-1:0]     r_off;
   logic [XLEN-1:0]   r_beat0;
   logic [ADDR_W-1:0] r_memAddr;
   logic [XLEN-1:0]   r_rspData;
   logic              r_mis;
   logic              r_ill;

   function automatic logic [3:0] size_of(input logic [2:0] f3);
      case (f3[1:0])
         2'b00:   return 4'd1;
         2'b01:   return 4'd2;
         2'b10:   return 4'd4;
         default: return 4'd8;
      endcase
   endfunction

   function automatic logic legal_f3(input logic [2:0] f3);
      case (f3)
         3'b000, 3'b001, 3'b010,
         3'b100, 3'b101:  return 1'b1;
         3'b011, 3'b110:  return (XLEN == 64);
         default:         return 1'b0;
      endcase
   endfunction

   logic          w_accept;
   logic          w_in_legal;
   logic          w_in_bad_mis;
   logic [3:0]    w_size;
   logic          w_split;

   assign w_accept   = bus.reqValid && (r_state == IDLE);
   assign w_in_legal = legal_f3(bus.funct3);
   assign w_size     = size_of(r_f3);

`ifdef MISALIGN_SPLIT_EN
   assign w_in_bad_mis = 1'b0;
   assign w_split = ({1'b0, 4'(r_off)} + {1'b0, w_size}) > 5'(NB);
`else
   logic [3:0] w_in_size;
   assign w_in_size    = size_of(bus.funct3);
   assign w_in_bad_mis = (4'(bus.addr[OW-1:0]) & (w_in_size - 4'd1)) != 4'd0;
   assign w_split      = 1'b0;
`endif

   // Merge the two beats, drop the low offset bytes, then extend.
   logic [XLEN-1:0]        w_lo;
   logic [XLEN-1:0]        w_hi;
   logic [XLEN-1:0]        w_low;
   logic [SW-1:0]          w_sa;
   logic [XLEN-1:0]        w_up;
   logic signed [XLEN-1:0] w_ups;
   logic [XLEN-1:0]        w_sext;
   logic [XLEN-1:0]        w_zext;
   logic [XLEN-1:0]        w_ext;

   assign w_lo   = (r_state == BEAT0) ? bus.memRdata : r_beat0;
   assign w_hi   = (r_state == BEAT1) ? bus.memRdata : '0;
   assign w_low  = XLEN'({w_hi, w_lo} >> {r_off, 3'b000});
   assign w_sa   = SW'(XLEN) - SW'({w_size, 3'b000});
   assign w_up   = w_low << w_sa;
   assign w_ups  = w_up;
   assign w_sext = w_ups >>> w_sa;
   assign w_zext = w_up >> w_sa;
   assign w_ext  = r_f3[2] ? w_zext : w_sext;

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE: begin
            if (bus.reqValid) begin
               if (!w_in_legal || w_in_bad_mis) w_next = RESP;
               else                             w_next = BEAT0;
            end
         end
         BEAT0: if (bus.memAck) w_next = w_split ? BEAT1 : RESP;
         BEAT1: if (bus.memAck) w_next = RESP;
         RESP:  w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= IDLE;
         r_f3      <= '0;
         r_off     <= '0;
         r_beat0   <= '0;
         r_memAddr <= '0;
         r_rspData <= '0;
         r_mis     <= 1'b0;
         r_ill     <= 1'b0;
      end else begin
         r_state   <= w_next;
         r_rspData <= '0;
         r_mis     <= 1'b0;
         r_ill     <= 1'b0;
         if (w_accept) begin
            r_f3      <= bus.funct3;
            r_off     <= bus.addr[OW-1:0];
            r_memAddr <= bus.addr & ~ADDR_W'(NB - 1);
            r_ill     <= !w_in_legal;
            r_mis     <= w_in_legal && w_in_bad_mis;
         end
         if (r_state == BEAT0 && bus.memAck) begin
            r_beat0 <= bus.memRdata;
            if (w_split) r_memAddr <= r_memAddr + ADDR_W'(NB);
            else         r_rspData <= w_ext;
         end
         if (r_state == BEAT1 && bus.memAck) r_rspData <= w_ext;
      end
   end

   assign bus.reqReady    = (r_state == IDLE);
   assign bus.memReq      = (r_state == BEAT0) || (r_state == BEAT1);
   assign bus.memAddr     = r_memAddr;
   assign bus.rspValid    = (r_state == RESP);
   assign bus.rspData     = r_rspData;
   assign bus.rspMisalign = r_mis;
   assign bus.rspIllegal  = r_ill;
endmodule

// File: tb/tb_load_align_unit.sv
// Directed bench for load_align_unit at XLEN=32 and XLEN=64.
module tb_load_align_unit;
   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   load_align_unit_if #(.XLEN(32), .ADDR_W(32)) b32 ();
   load_align_unit_if #(.XLEN(64), .ADDR_W(32)) b64 ();

   load_align_unit #(.XLEN(32), .ADDR_W(32)) u32 (
      .clk(clk), .reset(reset), .bus(b32));
   load_align_unit #(.XLEN(64), .ADDR_W(32)) u64 (
      .clk(clk), .reset(reset), .bus(b64));

   int tests = 0;
   int fails = 0;

   logic [31:0] r_d;
   logic [63:0] r_d64;
   logic        r_mis, r_ill, r_gap, r_done;
   int          r_beats, r_lat;
   logic [31:0] r_a0, r_a1;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic run32(input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] d0, input logic [31:0] d1,
                        input int wt);
      int w, ack_c;
      r_beats = 0; r_gap = 0; r_done = 0; r_d = 'x;
      r_mis = 0; r_ill = 0; r_a0 = '0; r_a1 = '0;
      r_lat = -1; w = 0; ack_c = -100;
      b32.reqValid = 1'b1; b32.funct3 = f3; b32.addr = a;
      tick;
      b32.reqValid = 1'b0;
      for (int c = 0; c < 40 && !r_done; c++) begin
         if (b32.rspValid) begin
            r_d = b32.rspData; r_mis = b32.rspMisalign;
            r_ill = b32.rspIllegal; r_lat = c - ack_c; r_done = 1;
         end else begin
            if (b32.memReq) begin
               if (w == 0) begin
                  if (r_beats == 0) r_a0 = b32.memAddr;
                  else              r_a1 = b32.memAddr;
               end
               if (w >= wt) begin
                  b32.memAck = 1'b1;
                  b32.memRdata = (r_beats == 0) ? d0 : d1;
                  r_beats++; w = 0; ack_c = c;
               end else w++;
            end else if (r_beats > 0) r_gap = 1;
            tick;
            b32.memAck = 1'b0;
         end
      end
      tick;
   endtask

   task automatic run64(input logic [2:0] f3, input logic [31:0] a,
                        input logic [63:0] d0);
      r_beats = 0; r_done = 0; r_d64 = 'x;
      r_mis = 0; r_ill = 0; r_a0 = '0;
      b64.reqValid = 1'b1; b64.funct3 = f3; b64.addr = a;
      tick;
      b64.reqValid = 1'b0;
      for (int c = 0; c < 40 && !r_done; c++) begin
         if (b64.rspValid) begin
            r_d64 = b64.rspData; r_mis = b64.rspMisalign;
            r_ill = b64.rspIllegal; r_done = 1;
         end else begin
            if (b64.memReq) begin
               r_a0 = b64.memAddr;
               b64.memAck = 1'b1; b64.memRdata = d0; r_beats++;
            end
            tick;
            b64.memAck = 1'b0;
         end
      end
      tick;
   endtask

   task automatic test_reset;
      reset = 1'b1; tick; tick; reset = 1'b0; tick;
      tests++; if (b32.reqReady !== 1'b1) begin fails++; $display("FAIL rst_ready got %b exp 1", b32.reqReady); end
      tests++; if (b32.memReq !== 1'b0) begin fails++; $display("FAIL rst_memreq got %b exp 0", b32.memReq); end
      tests++; if (b32.memAddr !== 32'h0) begin fails++; $display("FAIL rst_memaddr got %h exp 0", b32.memAddr); end
      tests++; if (b32.rspValid !== 1'b0) begin fails++; $display("FAIL rst_rspvalid got %b exp 0", b32.rspValid); end
      tests++; if (b32.rspData !== 32'h0) begin fails++; $display("FAIL rst_rspdata got %h exp 0", b32.rspData); end
      tests++; if ({b32.rspMisalign, b32.rspIllegal} !== 2'b00) begin fails++; $display("FAIL rst_flags got %b exp 00", {b32.rspMisalign, b32.rspIllegal}); end
      tests++; if (b64.reqReady !== 1'b1) begin fails++; $display("FAIL rst_ready64 got %b exp 1", b64.reqReady); end
   endtask

   task automatic test_lw_aligned;
      run32(3'b010, 32'h100, 32'hDEADBEEF, 32'h0, 2);
      tests++; if (r_done !== 1'b1) begin fails++; $display("FAIL lw_timeout got %b exp 1", r_done); end
      tests++; if (r_a0 !== 32'h100) begin fails++; $display("FAIL lw_addr got %h exp 00000100", r_a0); end
      tests++; if (r_beats !== 1) begin fails++; $display("FAIL lw_beats got %0d exp 1", r_beats); end
      tests++; if (r_d !== 32'hDEADBEEF) begin fails++; $display("FAIL lw_data got %h exp deadbeef", r_d); end
      tests++; if (r_lat !== 1) begin fails++; $display("FAIL lw_latency got %0d exp 1", r_lat); end
      tests++; if (b32.reqReady !== 1'b1) begin fails++; $display("FAIL lw_ready got %b exp 1", b32.reqReady); end
   endtask

   task automatic test_byte_half_ext;
      run32(3'b000, 32'h103, 32'h80112233, 32'h0, 0);
      tests++; if (r_d !== 32'hFFFFFF80) begin fails++; $display("FAIL lb_data got %h exp ffffff80", r_d); end
      tests++; if (r_a0 !== 32'h100) begin fails++; $display("FAIL lb_addr got %h exp 00000100", r_a0); end
      run32(3'b100, 32'h103, 32'h80112233, 32'h0, 1);
      tests++; if (r_d !== 32'h00000080) begin fails++; $display("FAIL lbu_data got %h exp 00000080", r_d); end
      run32(3'b001, 32'h102, 32'h80112233, 32'h0, 0);
      tests++; if (r_d !== 32'hFFFF8011) begin fails++; $display("FAIL lh_data got %h exp ffff8011", r_d); end
      run32(3'b101, 32'h102, 32'h80112233, 32'h0, 0);
      tests++; if (r_d !== 32'h00008011) begin fails++; $display("FAIL lhu_data got %h exp 00008011", r_d); end
   endtask

   task automatic test_misalign;
      run32(3'b001, 32'h1FF, 32'hAB000000, 32'h000000CD, 0);
      tests++; if (r_done !== 1'b1) begin fails++; $display("FAIL mis_timeout got %b exp 1", r_done); end
`ifdef MISALIGN_SPLIT_EN
      tests++; if (r_beats !== 2) begin fails++; $display("FAIL split_beats got %0d exp 2", r_beats); end
      tests++; if (r_a0 !== 32'h1FC || r_a1 !== 32'h200) begin fails++; $display("FAIL split_addr got %h/%h exp 000001fc/00000200", r_a0, r_a1); end
      tests++; if (r_gap !== 1'b0) begin fails++; $display("FAIL split_gap got %b exp 0", r_gap); end
      tests++; if (r_d !== 32'hFFFFCDAB || r_mis !== 1'b0) begin fails++; $display("FAIL split_data got %h mis %b exp ffffcdab mis 0", r_d, r_mis); end
      run32(3'b001, 32'h101, 32'h80112233, 32'h0, 0);
      tests++; if (r_d !== 32'h00001122 || r_beats !== 1) begin fails++; $display("FAIL inword_data got %h beats %0d exp 00001122 beats 1", r_d, r_beats); end
      run32(3'b010, 32'hFFFFFFFE, 32'hBEEF0000, 32'h0000DEAD, 1);
      tests++; if (r_a1 !== 32'h0 || r_d !== 32'hDEADBEEF) begin fails++; $display("FAIL wrap got addr %h data %h exp 00000000 deadbeef", r_a1, r_d); end
`else
      tests++; if (r_beats !== 0) begin fails++; $display("FAIL mis_memreq got %0d beats exp 0", r_beats); end
      tests++; if (r_mis !== 1'b1 || r_d !== 32'h0) begin fails++; $display("FAIL mis_rsp got mis %b data %h exp 1 00000000", r_mis, r_d); end
      run32(3'b001, 32'h101, 32'h80112233, 32'h0, 0);
      tests++; if (r_mis !== 1'b1 || r_beats !== 0) begin fails++; $display("FAIL mis_inword got mis %b beats %0d exp 1 0", r_mis, r_beats); end
      run32(3'b010, 32'hFFFFFFFE, 32'hBEEF0000, 32'h0000DEAD, 1);
      tests++; if (r_mis !== 1'b1 || r_d !== 32'h0) begin fails++; $display("FAIL mis_lw got mis %b data %h exp 1 00000000", r_mis, r_d); end
`endif
      tests++; if (r_ill !== 1'b0) begin fails++; $display("FAIL mis_ill got %b exp 0", r_ill); end
   endtask

   task automatic test_illegal32;
      run32(3'b011, 32'h100, 32'h12345678, 32'h0, 0);
      tests++; if (r_done !== 1'b1 || r_lat == 1) begin fails++; $display("FAIL ill_resp got done %b lat %0d exp 1", r_done, r_lat); end
      tests++; if (r_ill !== 1'b1 || r_d !== 32'h0) begin fails++; $display("FAIL ill_rsp got ill %b data %h exp 1 00000000", r_ill, r_d); end
      tests++; if (r_beats !== 0) begin fails++; $display("FAIL ill_memreq got %0d beats exp 0", r_beats); end
      tests++; if (b32.reqReady !== 1'b1) begin fails++; $display("FAIL ill_ready got %b exp 1", b32.reqReady); end
      run32(3'b110, 32'h100, 32'h12345678, 32'h0, 0);
      tests++; if (r_ill !== 1'b1 || r_beats !== 0) begin fails++; $display("FAIL lwu32_ill got ill %b beats %0d exp 1 0", r_ill, r_beats); end
   endtask

   task automatic test_xlen64;
      run64(3'b011, 32'h8, 64'h8000_0000_0000_0001);
      tests++; if (r_d64 !== 64'h8000000000000001 || r_a0 !== 32'h8) begin fails++; $display("FAIL ld64 got %h @%h exp 8000000000000001 @00000008", r_d64, r_a0); end
      run64(3'b110, 32'hC, 64'hF0000000_00000000);
      tests++; if (r_d64 !== 64'h00000000F0000000 || r_a0 !== 32'h8) begin fails++; $display("FAIL lwu64 got %h @%h exp 00000000f0000000 @00000008", r_d64, r_a0); end
      run64(3'b010, 32'hC, 64'hF0000000_00000000);
      tests++; if (r_d64 !== 64'hFFFFFFFFF0000000) begin fails++; $display("FAIL lw64 got %h exp fffffffff0000000", r_d64); end
      run64(3'b111, 32'h8, 64'h1);
      tests++; if (r_ill !== 1'b1 || r_beats !== 0 || r_d64 !== 64'h0) begin fails++; $display("FAIL ill64 got ill %b beats %0d data %h", r_ill, r_beats, r_d64); end
   endtask

   task automatic test_reset_mid;
      b32.reqValid = 1'b1; b32.funct3 = 3'b010; b32.addr = 32'h40;
      tick;
      b32.reqValid = 1'b0;
      tests++; if (b32.memReq !== 1'b1 || b32.memAddr !== 32'h40) begin fails++; $display("FAIL mid_beat0 got req %b addr %h exp 1 00000040", b32.memReq, b32.memAddr); end
      reset = 1'b1; tick; reset = 1'b0;
      tests++; if (b32.memReq !== 1'b0 || b32.rspValid !== 1'b0 || b32.reqReady !== 1'b1) begin fails++; $display("FAIL mid_reset got req %b rsp %b rdy %b exp 0 0 1", b32.memReq, b32.rspValid, b32.reqReady); end
      b32.memAck = 1'b1; b32.memRdata = 32'hCAFEF00D;
      tick;
      b32.memAck = 1'b0;
      tests++; if (b32.rspValid !== 1'b0 || b32.memReq !== 1'b0) begin fails++; $display("FAIL mid_stray got rsp %b req %b exp 0 0", b32.rspValid, b32.memReq); end
      tick;
      tests++; if (b32.rspValid !== 1'b0) begin fails++; $display("FAIL mid_stray2 got rsp %b exp 0", b32.rspValid); end
      run32(3'b010, 32'h44, 32'h12345678, 32'h0, 0);
      tests++; if (r_d !== 32'h12345678 || r_a0 !== 32'h44) begin fails++; $display("FAIL mid_next got %h @%h exp 12345678 @00000044", r_d, r_a0); end
   endtask

   task automatic test_back_to_back;
      run32(3'b010, 32'h200, 32'h01020304, 32'h0, 0);
      tests++; if (r_d !== 32'h01020304 || r_lat !== 1) begin fails++; $display("FAIL b2b_first got %h lat %0d exp 01020304 1", r_d, r_lat); end
      run32(3'b000, 32'h201, 32'h01020304, 32'h0, 3);
      tests++; if (r_d !== 32'h00000003 || r_a0 !== 32'h200) begin fails++; $display("FAIL b2b_second got %h @%h exp 00000003 @00000200", r_d, r_a0); end
   endtask

   initial begin
      b32.reqValid = 1'b0; b32.funct3 = '0; b32.addr = '0;
      b32.memAck = 1'b0; b32.memRdata = '0;
      b64.reqValid = 1'b0; b64.funct3 = '0; b64.addr = '0;
      b64.memAck = 1'b0; b64.memRdata = '0;
      test_reset;
      test_lw_aligned;
      test_byte_half_ext;
      test_misalign;
      test_illegal32;
      test_xlen64;
      test_reset_mid;
      test_back_to_back;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/load_align_unit.md
Name: load_align_unit

Overview:
Parametrised, sequential successor to the single-cycle load formatter: accepts one load request, performs the aligned memory read(s) over a req/ack handshake, then extracts, merges and sign/zero-extends the addressed field. Supports XLEN 32 or 64, standard RISC-V funct3 load encodings, and a split into two aligned beats for misaligned accesses. Sits between the execute stage and the data-memory port of the multi-cycle core.

Parameters:
XLEN, 32, data/register width; legal values 32 or 64
ADDR_W, 32, byte-address width

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  synchronous, active-high reset
reqValid  input  1  load request present
reqReady  output  1  unit can accept a request (high only in IDLE)
funct3  input  3  load type: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu; XLEN=64 adds 011 ld, 110 lwu
addr  input  ADDR_W  byte address of load
memReq  output  1  memory read request, held until memAck
memAddr  output  ADDR_W  aligned read address (low log2(XLEN/8) bits zero)
memAck  input  1  read complete; memRdata valid this cycle
memRdata  input  XLEN  aligned read data, little-endian
rspValid  output  1  one-cycle pulse: result valid
rspData  output  XLEN  extended load result
rspMisalign  output  1  with rspValid: access misaligned and not performed
rspIllegal  output  1  with rspValid: funct3 not legal for XLEN

Behaviour:
- Reset: state IDLE; reqReady=1 after reset deasserts; memReq=0, memAddr=0, rspValid=0, rspData=0, rspMisalign=0, rspIllegal=0.
- States: IDLE, BEAT0, BEAT1, RESP. Handshake accepted when reqValid&&reqReady; addr/funct3 latched that edge; inputs ignored outside IDLE.
- Size from funct3[1:0]: 1/2/4/8 bytes. off = addr mod (XLEN/8). Misaligned = off not multiple of size. Split needed = off+size > XLEN/8.
- Illegal funct3: IDLE -> RESP, no memReq; rspValid next cycle, rspIllegal=1, rspData=0.
- Legal: IDLE -> BEAT0; memReq=1, memAddr=addr with low bits cleared, from cycle after accept.
- BEAT0 + memAck: capture memRdata into beat0; if no split -> RESP, else -> BEAT1 with memReq held high and memAddr advanced by XLEN/8 (wraps modulo 2^ADDR_W). memReq never drops between beats.
- BEAT1 + memAck: capture beat1 -> RESP.
- RESP: memReq=0, rspValid=1 for exactly one cycle, then IDLE (reqReady=1). No output backpressure.
- Extraction: form {beat1,beat0} (beat1=0 if unused), shift right by off*8, keep low size*8 bits; signed types replicate top kept bit, unsigned (100, 101, 110) zero-fill to XLEN.
- Latency: aligned load with memAck in cycle A -> rspValid in A+1. Minimum accept-to-response 3 cycles (zero-wait ack), 4 with split.
- memAck while memReq=0 ignored. Outputs registered; no combinational path memAck->memReq/rspValid.
- Reset mid-operation: next edge forces IDLE, memReq=0, no rspValid; later stray memAck ignored.

Optional Feature:
MISALIGN_SPLIT_EN defined: misaligned loads split into two beats as above; rspMisalign always 0.
Undefined: misaligned legal load goes IDLE -> RESP with no memReq; rspValid next cycle with rspMisalign=1, rspData=0; BEAT1 unreachable.

Test Plan:
- XLEN=32, lw addr 0x100, memRdata=0xDEADBEEF, ack 2 cycles after memReq -> memAddr=0x100, single beat, rspData=0xDEADBEEF one cycle after ack.
- XLEN=32, lb addr 0x103 and lbu addr 0x103, memRdata=0x80112233 -> rspData=0xFFFFFF80 and 0x00000080.
- XLEN=32, lh addr 0x1FF, MISALIGN_SPLIT_EN on, beats 0xAB000000 @0x1FC then 0x000000CD @0x200 -> memReq held across both, rspData=0xFFFFCDAB; with macro off -> no memReq, rspMisalign=1, rspData=0.
- XLEN=64, ld addr 0x8, memRdata=0x8000_0000_0000_0001 -> rspData=0x8000000000000001; lwu addr 0xC, memRdata=0xF0000000_00000000 -> 0x00000000F0000000; funct3=111 -> rspIllegal=1, no memReq.
- XLEN=32, funct3=011 -> rspIllegal=1 next cycle, memReq stays 0, reqReady back high cycle after.
- reset asserted in BEAT0 with memReq high, memAck pulsed after reset -> memReq=0 next edge, no rspValid, reqReady=1, next lw completes normally.
